fetch_stage: RTL

- Instruction fetch stage of the 5-stage RV32I pipeline.
- Generates the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a small FIFO and presents {instr, pc, pc+4} to decode under a valid/ready handshake.
- Decode slices instr[31:7] for the immediate generator. Branch/jump redirects from EX flush the stage.

---
 rtl/rv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline types and constants.
//   XLEN             datapath / PC width
//   RESET_PC_DEFAULT first fetch address after reset
//   NOP              canonical addi x0,x0,0 encoding (reference only)
//   fetch_entry_t    one buffered fetch result: {instr, pc}
package rv_pkg;

   localparam int unsigned      XLEN             = 32;
   localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0]      NOP              = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used as the fetch instruction buffer.
//   clk, rst_n  clock and synchronous active-low reset
//   push, wdata write one entry
//   pop         retire the head entry
//   clear       empty the FIFO; wins over push
//   full        FIFO holds DEPTH entries
//   count       number of valid entries (0..DEPTH)
//   head        oldest entry (undefined contents when count == 0)
// DEPTH must be a power of two so the pointers wrap by overflow.
module fetch_fifo #(
   parameter  int unsigned WIDTH = 64,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
      mem_q <= mem_d;
   end

   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage.
// Generates the PC, issues word reads to a 1-cycle-latency instruction
// memory, buffers responses and hands {instr, pc, pc+4} to decode under
// a valid/ready handshake. An EX redirect flushes the buffer and restarts
// fetch at the (word-aligned) target.
//   clk, rst_n        clock, synchronous active-low reset
//   imem_req/addr     instruction memory read request / word address
//   imem_rdata        read data, valid the cycle after imem_req
//   if_valid/instr/pc/pc_plus4  head entry towards decode
//   id_ready          decode accepts the head entry
//   redirect_valid/pc branch / jump / flush from EX
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters
//   perf_stall_cnt (if_valid && !id_ready cycles) and
//   perf_flush_cnt (redirect_valid cycles).
module fetch_stage #(
   parameter int unsigned     XLEN       = rv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = rv_pkg::RESET_PC_DEFAULT,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [31:0]     if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_plus4,
   input  logic            id_ready,
   input  logic            redirect_valid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]     perf_stall_cnt,
   output logic [31:0]     perf_flush_cnt,
`endif
   input  logic [XLEN-1:0] redirect_pc
);

   import rv_pkg::*;

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW = CW + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_resp_q, pc_resp_d;
   logic            inflight_q, inflight_d;
   logic            pop, push;
   logic [OW-1:0]   occupancy;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full_unused;
   logic [$bits(fetch_entry_t)-1:0] fifo_head;
   fetch_entry_t    wr_entry, head_entry;
   logic            unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign wr_entry             = {imem_rdata, pc_resp_q};

   always_comb begin
      head_entry = fetch_entry_t'(fifo_head);
      // Combinational outputs are forced quiet while reset is asserted,
      // even on the first reset cycle before the state has been cleared.
      if_valid    = rst_n && (fifo_count != '0);
      if_instr    = if_valid ? head_entry.instr : '0;
      if_pc       = if_valid ? head_entry.pc : '0;
      if_pc_plus4 = if_valid ? head_entry.pc + XLEN'(4) : '0;

      pop = if_valid && id_ready && !redirect_valid;
      // Entries already buffered plus the one still in flight, less the one
      // leaving this cycle, must leave room for the response of a new request.
      occupancy = OW'(fifo_count) + OW'(inflight_q) - OW'(pop);
      imem_req  = rst_n && (redirect_valid || (occupancy < OW'(FIFO_DEPTH)));
      imem_addr = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : pc_q;

      pc_d       = imem_req ? imem_addr + XLEN'(4) : pc_q;
      pc_resp_d  = imem_req ? imem_addr : pc_resp_q;
      inflight_d = imem_req;
      // A response landing in a redirect cycle belongs to the wrong path.
      push = inflight_q && !redirect_valid;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         pc_resp_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pc_resp_q  <= pc_resp_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clear (redirect_valid),
      .wdata (wr_entry),
      .full  (fifo_full_unused),
      .count (fifo_count),
      .head  (fifo_head)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;

   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (if_valid && !id_ready && (perf_stall_q != '1)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if (redirect_valid && (perf_flush_q != '1)) begin
         perf_flush_d = perf_flush_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
